// File: rtl/sobel_magnitude_if.sv
// Gradient-in / magnitude-out handshake bundle for the Sobel magnitude stage.
interface sobel_magnitude_if #(
   parameter int WIDTH_P = 8
);
   logic                          valid_i;
   logic                          ready_o;
   logic signed [2*WIDTH_P-1:0]   gx_i;
   logic signed [2*WIDTH_P-1:0]   gy_i;
   logic        [WIDTH_P-1:0]     thresh_i;
   logic                          valid_o;
   logic                          ready_i;
   logic        [WIDTH_P-1:0]     mag_o;
   logic                          edge_o;
   logic                          last_o;

   // Producer side: drives gradients and thresholds, consumes magnitude beats.
   modport master (
      output valid_i, gx_i, gy_i, thresh_i, ready_i,
      input  ready_o, valid_o, mag_o, edge_o, last_o
   );

   // Magnitude block side.
   modport slave (
      input  valid_i, gx_i, gy_i, thresh_i, ready_i,
      output ready_o, valid_o, mag_o, edge_o, last_o
   );
endinterface

// File: rtl/sobel_magnitude.sv
// Sobel L1 magnitude stage: |gx|+|gy| saturated to pixel width, border
// suppression, thresholded edge bit, frame-last marker. Two register stages
// sharing a single advance enable so a downstream stall freezes everything.
module sobel_magnitude #(
   parameter int WIDTH_P  = 8,
   parameter int DEPTH_P  = 16,
   parameter int HEIGHT_P = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   sobel_magnitude_if.slave bus
);
   localparam int GW = 2 * WIDTH_P;
   localparam int SW = GW + 1;
   localparam int CW = (DEPTH_P  > 1) ? $clog2(DEPTH_P)  : 1;
   localparam int RW = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

   localparam logic [CW-1:0] COL_LAST = CW'(DEPTH_P - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT_P - 1);
   localparam logic [CW-1:0] COL_TWO  = CW'(2);
   localparam logic [RW-1:0] ROW_TWO  = RW'(2);
   localparam logic [SW-1:0] PIX_MAX  = SW'((1 << WIDTH_P) - 1);

   // Two's-complement magnitude as unsigned; the most-negative input maps
   // to 2^(GW-1), which still fits in GW unsigned bits.
   function automatic logic [GW-1:0] abs_val(input logic signed [GW-1:0] v);
      logic [GW-1:0] u;
      u = v;
      return v[GW-1] ? (~u + GW'(1)) : u;
   endfunction

   // Clamp the GW+1 bit sum to the pixel range.
   function automatic logic [WIDTH_P-1:0] sat_mag(input logic [SW-1:0] s);
      if (s > PIX_MAX) return '1;
      else             return s[WIDTH_P-1:0];
   endfunction

   logic                en;
   logic                accept;
   logic [CW-1:0]       col;
   logic [RW-1:0]       row;
   logic                border_now;
   logic                last_now;

   logic [GW-1:0]       ax_p1;
   logic [GW-1:0]       ay_p1;
   logic                border_p1;
   logic                last_p1;
   logic                vld_p1;

   logic [SW-1:0]       sum_p1;
   logic [WIDTH_P-1:0]  mag_p1;

   assign en          = ~bus.valid_o | bus.ready_i;
   assign bus.ready_o = en & ~rst_i;
   assign accept      = bus.valid_i & bus.ready_o;

   assign border_now  = (row < ROW_TWO) | (col < COL_TWO);
   assign last_now    = (row == ROW_LAST) & (col == COL_LAST);

   // Pixel position tracking; moves only when a pair is actually accepted.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         if (col == COL_LAST) begin
            col <= '0;
            row <= (row == ROW_LAST) ? '0 : row + RW'(1);
         end else begin
            col <= col + CW'(1);
         end
      end
   end

   // ---- stage 1: absolute values plus position flags ----
   // Stage-1 valid; bubbles are loaded whenever the pipe advances without an accept.
   always_ff @(posedge clk_i) begin
      if (rst_i)   vld_p1 <= 1'b0;
      else if (en) vld_p1 <= accept;
   end

   // Stage-1 data payload; meaningless while vld_p1 is low, so not reset.
   always_ff @(posedge clk_i) begin
      if (en) begin
         ax_p1     <= abs_val(bus.gx_i);
         ay_p1     <= abs_val(bus.gy_i);
         border_p1 <= border_now;
         last_p1   <= last_now;
      end
   end

   // ---- stage 2: sum, saturate, border mask, threshold ----
   assign sum_p1 = {1'b0, ax_p1} + {1'b0, ay_p1};
   assign mag_p1 = sat_mag(sum_p1);

   // Output register; held while the consumer stalls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bus.valid_o <= 1'b0;
         bus.mag_o   <= '0;
         bus.edge_o  <= 1'b0;
         bus.last_o  <= 1'b0;
      end else if (en) begin
         bus.valid_o <= vld_p1;
         bus.mag_o   <= border_p1 ? '0 : mag_p1;
         bus.edge_o  <= ~border_p1 & (mag_p1 >= bus.thresh_i);
         bus.last_o  <= last_p1;
      end
   end
endmodule

// File: tb/tb_sobel_magnitude.sv
// Scoreboard bench for sobel_magnitude: a position-tracking reference model
// pushes the expected beat on every accept; output transfers pop and compare.
module tb_sobel_magnitude;
   localparam int W  = 8;
   localparam int D  = 16;
   localparam int H  = 16;
   localparam int GW = 2 * W;

   typedef struct {
      int mag;
      int edg;
      int lst;
   } exp_t;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;

   sobel_magnitude_if #(.WIDTH_P(W)) bus ();

   sobel_magnitude #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   exp_t q[$];
   int   checks = 0;
   int   passed = 0;
   int   mrow = 0, mcol = 0;
   int   cyc = 0;
   int   first_a = -1, first_v = -1;
   bit   track = 1'b0;
   int   out_cnt = 0, last_cnt = 0, last_idx = -1;
   int   first_mag = -1;
   bit   acc_now = 1'b0;
   bit   held = 1'b0;
   int   hmag, hedge, hlast;
   int   tbl_idx = 0;

   int gx_tbl[8] = '{-1020, -3, -32768, 10, 32767, 0, -200, 127};
   int gy_tbl[8] = '{ 1020,  4,      0, -10, 32767, 0,   56, 127};

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Reference for one accepted pair at the model's current position.
   task automatic model_push(input int x, input int y);
      exp_t e;
      int ax, ay, s, m;
      bit border;
      border = (mrow < 2) || (mcol < 2);
      ax = (x < 0) ? -x : x;
      ay = (y < 0) ? -y : y;
      s  = ax + ay;
      m  = (s > 255) ? 255 : s;
      e.mag = border ? 0 : m;
      e.edg = (!border && (m >= int'(bus.thresh_i))) ? 1 : 0;
      e.lst = ((mrow == H - 1) && (mcol == D - 1)) ? 1 : 0;
      q.push_back(e);
      if (mcol == D - 1) begin
         mcol = 0;
         mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
         mcol = mcol + 1;
      end
   endtask

   // One clock: drive at the falling edge, sample 1ns later.
   task automatic step(input bit v, input int x, input int y, input bit rdy);
      exp_t e;
      @(negedge clk_i);
      bus.valid_i = v;
      bus.gx_i    = GW'(x);
      bus.gy_i    = GW'(y);
      bus.ready_i = rdy;
      #1;
      cyc++;
      chk("ready_o", int'(bus.ready_o), int'(!bus.valid_o || bus.ready_i));
      if (held) begin
         chk("hold_mag",  int'(bus.mag_o),   hmag);
         chk("hold_edge", int'(bus.edge_o),  hedge);
         chk("hold_last", int'(bus.last_o),  hlast);
         chk("hold_valid", int'(bus.valid_o), 1);
      end
      if (bus.valid_o && bus.ready_i) begin
         if (track && first_v < 0) first_v = cyc;
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            e = q.pop_front();
            chk("mag",  int'(bus.mag_o),  e.mag);
            chk("edge", int'(bus.edge_o), e.edg);
            chk("last", int'(bus.last_o), e.lst);
            out_cnt++;
            if (first_mag < 0) first_mag = int'(bus.mag_o);
            if (bus.last_o) begin
               last_cnt++;
               last_idx = out_cnt;
            end
         end
      end
      held  = bus.valid_o && !bus.ready_i;
      hmag  = int'(bus.mag_o);
      hedge = int'(bus.edge_o);
      hlast = int'(bus.last_o);
      acc_now = bus.valid_i && bus.ready_o;
      if (acc_now) begin
         if (track && first_a < 0) first_a = cyc;
         model_push(x, y);
      end
   endtask

   task automatic gen(input int mode, output int x, output int y);
      case (mode)
         0: begin x = 10; y = 10; end
         1: begin
            x = gx_tbl[tbl_idx % 8];
            y = gy_tbl[tbl_idx % 8];
            tbl_idx++;
         end
         default: begin
            x = int'($urandom_range(65535)) - 32768;
            y = int'($urandom_range(65535)) - 32768;
            if ($urandom_range(1) == 0) begin
               x = x % 200;
               y = y % 200;
            end
         end
      endcase
   endtask

   // Feed n accepted pairs; data is held until taken, gap idle cycles follow each accept.
   task automatic stream(input int n, input int mode, input int rpct, input int gap);
      int got = 0, idle = 0, guard = 0, x = 0, y = 0;
      bit have = 1'b0;
      while (got < n && guard < 20000) begin
         guard++;
         if (!have) begin
            gen(mode, x, y);
            have = 1'b1;
         end
         step(idle == 0, x, y, $urandom_range(99) < rpct);
         if (acc_now) begin
            got++;
            have = 1'b0;
            idle = gap;
         end else if (idle > 0) begin
            idle--;
         end
      end
      if (got < n) chk("stream_timeout", got, n);
   endtask

   task automatic drain();
      int g = 0;
      while (q.size() > 0 && g < 64) begin
         step(1'b0, 0, 0, 1'b1);
         g++;
      end
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i       = 1'b1;
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      #1;
      chk("rst_ready_o", int'(bus.ready_o), 0);
      @(negedge clk_i);
      rst_i       = 1'b0;
      bus.ready_i = 1'b1;
      #1;
      chk("rst_valid_o", int'(bus.valid_o), 0);
      chk("rst_mag_o",   int'(bus.mag_o),   0);
      chk("rst_edge_o",  int'(bus.edge_o),  0);
      chk("rst_last_o",  int'(bus.last_o),  0);
      q.delete();
      mrow = 0;
      mcol = 0;
      held = 1'b0;
   endtask

   task automatic seg_start();
      out_cnt   = 0;
      last_cnt  = 0;
      last_idx  = -1;
      first_mag = -1;
   endtask

   initial begin
      bus.valid_i  = 1'b0;
      bus.gx_i     = '0;
      bus.gy_i     = '0;
      bus.ready_i  = 1'b0;
      bus.thresh_i = 8'd15;
      repeat (2) @(posedge clk_i);
      do_reset();

      // Uniform frame, full-rate consumer, latency measurement.
      seg_start();
      track = 1'b1;
      stream(D * H, 0, 100, 0);
      drain();
      track = 1'b0;
      chk("latency", first_v - first_a, 2);
      chk("frame1_count", out_cnt, D * H);
      chk("frame1_last_cnt", last_cnt, 1);
      chk("frame1_last_idx", last_idx, D * H);

      // Saturation, most-negative input and small values, threshold 200.
      bus.thresh_i = 8'd200;
      seg_start();
      stream(D * H, 1, 100, 0);
      drain();
      chk("frame2_count", out_cnt, D * H);

      // Threshold extremes with random gradients.
      bus.thresh_i = 8'd0;
      stream(D * H, 2, 100, 0);
      drain();
      bus.thresh_i = 8'd255;
      stream(D * H, 2, 100, 0);
      drain();

      // Random back-pressure over two frames.
      bus.thresh_i = 8'd15;
      seg_start();
      stream(2 * D * H, 1, 50, 0);
      drain();
      chk("bp_count", out_cnt, 2 * D * H);
      chk("bp_last_cnt", last_cnt, 2);

      // Reset mid-frame with beats in flight.
      stream(40, 2, 50, 0);
      do_reset();
      seg_start();
      stream(D * H, 0, 100, 0);
      drain();
      chk("post_rst_first_mag", first_mag, 0);
      chk("post_rst_last_idx", last_idx, D * H);
      chk("post_rst_last_cnt", last_cnt, 1);

      // Input gaps: one on, two off.
      seg_start();
      stream(D * H, 1, 100, 2);
      drain();
      chk("gap_count", out_cnt, D * H);
      chk("gap_last_idx", last_idx, D * H);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sobel_magnitude.md
Name: sobel_magnitude

Overview:
- Downstream consumer of the Sobel convolution stage. Takes one signed gradient pair (gx, gy) per accepted pixel.
- Computes the L1 magnitude |gx|+|gy| and saturates it to pixel width.
- Zeroes frame-border outputs, where the 3x3 window is not yet filled with valid pixels.
- Produces a thresholded edge bit. Two-stage valid/ready pipeline that feeds the output/pixel-packing stage.

Parameters:
- WIDTH_P, 8, pixel width. Gradient inputs are 2*WIDTH_P bits signed; magnitude output is WIDTH_P bits.
- DEPTH_P, 16, pixels per image row (line length). Must match the convolution stage.
- HEIGHT_P, 16, rows per frame. Must be >= 3.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  upstream gradient pair valid.
- ready_o  output  1  this block can accept a pair this cycle.
- gx_i  input  2*WIDTH_P  signed horizontal gradient.
- gy_i  input  2*WIDTH_P  signed vertical gradient.
- thresh_i  input  WIDTH_P  unsigned edge threshold; quasi-static, sampled in stage 2.
- valid_o  output  1  output beat valid.
- ready_i  input  1  downstream can accept.
- mag_o  output  WIDTH_P  saturated magnitude, or 0 at border positions.
- edge_o  output  1  1 when mag_o >= thresh_i and position is not border.
- last_o  output  1  marks the final pixel of a frame (row HEIGHT_P-1, col DEPTH_P-1).

Behaviour:
- Clock and reset: one clock, clk_i. Synchronous active-high reset rst_i.
- Reset values: valid_o=0, mag_o=0, edge_o=0, last_o=0, internal stage valids=0, col counter=0, row counter=0. ready_o is forced 0 while rst_i=1.
- Handshake:
  - Global advance enable en = !valid_o | ready_i.
  - ready_o = en (combinational) when not in reset.
  - Input accepted on valid_i & ready_o. Output transferred on valid_o & ready_i.
  - Stage registers load only when en=1. With en=0 every stage holds its contents, and outputs stay stable while valid_o=1 & ready_i=0.
  - No bubbles under continuous valid_i/ready_i; throughput is 1 pair/cycle.
- Latency: 2 cycles from acceptance to valid_o when not stalled.
- Position counters (advance only on input accept):
  - col increments and wraps DEPTH_P-1 -> 0. On wrap, row increments and wraps HEIGHT_P-1 -> 0.
  - border = (row < 2) | (col < 2). The upstream window is centred one row and one column behind the newest pixel, so positions with row < 2 or col < 2 are incomplete windows.
  - last = (row == HEIGHT_P-1) & (col == DEPTH_P-1).
  - border and last are captured in stage 1 alongside the data.
- Stage 1:
  - ax = |gx_i|, ay = |gy_i|, each as a 2*WIDTH_P-bit unsigned value.
  - The most-negative input maps to 2^(2*WIDTH_P-1); no overflow, because unsigned width holds it.
  - Registers ax, ay, border, last, and v1 = valid_i & ready_o (v1 reloads every en cycle).
- Stage 2:
  - sum = ax + ay in 2*WIDTH_P+1 bits.
  - mag = (sum > 2^WIDTH_P-1) ? 2^WIDTH_P-1 : sum[WIDTH_P-1:0].
  - mag_o <= border ? 0 : mag.
  - edge_o <= !border & (mag >= thresh_i).
  - last_o <= last; valid_o <= v1.
  - Border beats are still emitted, one output per input, so downstream pixel count is preserved.
- Boundary conditions:
  - thresh_i=0: every non-border beat has edge_o=1.
  - thresh_i=2^WIDTH_P-1: only saturated magnitudes produce edge_o=1.
  - Input accept and output stall in the same cycle cannot occur, since ready_o=0 whenever valid_o & !ready_i.
  - Input accept and output transfer in the same cycle: the pipeline shifts, no loss.
  - Counters hold during stalls and during valid_i=0 gaps; gaps insert bubbles (v1=0).
  - Reset mid-frame: in-flight beats are discarded, counters return to 0, and the next accepted pixel is treated as row 0, col 0.
  - Frame wrap: after last, the next accepted pixel is row 0, col 0 (border).

Test Plan:
- Reset then stream DEPTH_P*HEIGHT_P pairs (256 at defaults), gx=gy=10, thresh_i=15, ready_i=1 -> 256 outputs. The first 2 rows and cols 0-1 of every row give mag_o=0, edge_o=0; all others give mag_o=20, edge_o=1. last_o=1 only on beat 256. First valid_o 2 cycles after first accept.
- Non-border pixel with gx=-1020, gy=+1020 (WIDTH_P=8) -> mag_o=255 (saturated), edge_o=1 with thresh_i=200. gx=-3, gy=4 -> mag_o=7, edge_o=0.
- gx=-32768 (most negative) at a non-border position -> mag_o=255, no wrap to small values.
- Random ready_i (50%) with continuous valid_i over 2 frames -> output sequence identical to the ready_i=1 run. No drops or duplicates. mag_o/edge_o/last_o stable while valid_o & !ready_i.
- Assert rst_i for 1 cycle after 40 accepted pixels -> valid_o=0 next cycle. The next accepted pixel is border (mag_o=0). last_o appears after exactly 256 further accepts.
- valid_i gaps (1 on / 2 off) -> counters advance only on accepts; border/last positions match the gap-free run.
